operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Requester side of the integer register file: accepts decoded instructions, drives the register file's read addresses, and captures the registered read data into operands for execute.
- Owns the register file's write port. Forwards writeback results into it and keeps a busy-bit scoreboard so that no instruction reads, or re-targets, a register with a pending write.
- Sits between decode and execute in the multi-cycle core.

Parameters:
- XLEN, 32, data width of registers, operands and writeback data.
- PAYLOAD_W, 64, width of opaque decode payload (pc, imm, ALU op) carried unchanged to execute.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction available.
- in_ready  output  1  block accepts instruction this cycle.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- in_rd  input  5  destination index.
- in_we  input  1  instruction writes in_rd.
- in_payload  input  PAYLOAD_W  opaque decode fields.
- rf_rs1  output  5  register file read address 1.
- rf_rs2  output  5  register file read address 2.
- rf_rdata1  input  XLEN  register file registered read data 1.
- rf_rdata2  input  XLEN  register file registered read data 2.
- rf_rd  output  5  register file write address.
- rf_we  output  1  register file write enable.
- rf_wdata  output  XLEN  register file write data.
- wb_valid  input  1  writeback result this cycle; always accepted, no backpressure.
- wb_rd  input  5  writeback destination.
- wb_data  input  XLEN  writeback value.
- out_valid  output  1  operands valid to execute.
- out_ready  input  1  execute accepts operands.
- out_op1  output  XLEN  operand 1.
- out_op2  output  XLEN  operand 2.
- out_rd  output  5  destination.
- out_we  output  1  writes destination.
- out_payload  output  PAYLOAD_W  payload.

Behaviour:
- FSM states:
  - S_IDLE → S_READ on accept.
  - S_READ → S_CAPT unconditionally.
  - S_CAPT → S_OUT unconditionally.
  - S_OUT → S_IDLE when out_ready.
- Accept condition: S_IDLE && in_valid && !stall.
  - in_ready = S_IDLE && !stall. It is combinational and does not depend on in_valid.
- stall is high when any of these holds:
  - busy_eff[in_rs1] is set.
  - busy_eff[in_rs2] is set.
  - in_we && busy_eff[in_rd] is set (write-after-write ordering).
- busy_eff[i] = busy[i] && !(wb_valid && wb_rd==i). A same-cycle writeback releases the hazard. The regfile write lands on the same edge as accept, so the read edge one cycle later sees the new value.
- busy[0] is constantly 0. Indices equal to 0 never stall.
- On accept, latch rs1, rs2, rd, we and payload. If in_we && in_rd!=0, set busy[in_rd].
- On wb_valid, clear busy[wb_rd].
  - Set and clear of the same index on the same edge: set wins.
- rf_rs1/rf_rs2 drive the latched indices in S_READ and S_CAPT. They hold their last value in other states.
- The register file samples at the end of S_READ. rf_rdata is valid during S_CAPT and is registered into out_op1/out_op2 at the end of S_CAPT.
- Latency: accept edge E0, out_valid high after E2.
- In S_OUT, out_* are held stable while out_valid && !out_ready.
- Write port (combinational from the wb inputs):
  - rf_we = wb_valid && wb_rd!=0 && !rst.
  - rf_rd = wb_rd.
  - rf_wdata = wb_data.
- Writeback is independent of the FSM state and may occur in any cycle.
- Reset:
  - State becomes S_IDLE, all busy bits clear.
  - out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_we=0, out_payload=0.
  - rf_rs1=0, rf_rs2=0. in_ready=0 while rst is high.
  - Reset mid-operation abandons the in-flight instruction and drops its busy bit. No output pulse follows.
- After an accept with in_we && in_rd!=0 and no matching writeback, any instruction reading that register stalls indefinitely. Downstream must deliver a writeback for every out_we with nonzero out_rd.

Test Plan:
- Reset, then x5=0x1234 via wb; instr rs1=5, rs2=0, rd=6, we=1 -> out_valid 3 cycles after accept, out_op1=0x1234, out_op2=0, busy[6]=1.
- With busy[6] set, present instr rs1=6 -> in_ready=0 for all cycles until wb_valid rd=6 data=0xABCD. Accepted in that same cycle, and out_op1=0xABCD.
- Instr with rd=7 pending, new instr in_we=1, in_rd=7, sources free -> stalled until wb rd=7; WAW enforced.
- wb_valid with wb_rd=0, data=0xFFFF -> rf_we=0; instr rs1=0 -> out_op1=0; rd=0 with we=1 sets no busy bit.
- out_ready held low 5 cycles in S_OUT -> out_* stable, in_ready=0; out_ready high -> S_IDLE next cycle, in_ready=1.
- rst asserted during S_CAPT with busy[9] set -> out_valid=0 next cycle, busy all clear, instr rs1=9 accepted immediately after reset release.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: requester side of the integer register file.
// Accepts decoded instructions, drives the register file read addresses,
// captures the registered read data into operands for execute, and owns the
// register file write port. A busy-bit scoreboard blocks any instruction that
// would read, or re-target, a register with a pending writeback.
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_we,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output logic [4:0]           rf_rd,
  output logic                 rf_we,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic [PAYLOAD_W-1:0] out_payload
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            busy_q, busy_d;
  logic [4:0]             rf_rs1_q, rf_rs1_d;
  logic [4:0]             rf_rs2_q, rf_rs2_d;
  logic                   out_valid_q, out_valid_d;
  logic [XLEN-1:0]        out_op1_q, out_op1_d;
  logic [XLEN-1:0]        out_op2_q, out_op2_d;
  logic [4:0]             out_rd_q, out_rd_d;
  logic                   out_we_q, out_we_d;
  logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;

  logic [31:0]            wb_clr;
  logic [31:0]            acc_set;
  logic [31:0]            busy_eff;
  logic                   stall;
  logic                   accept;

  // Hazard detection: a writeback in this cycle releases its register early,
  // since the write lands on the accept edge and the read happens one edge later.
  always_comb begin
    wb_clr = 32'd0;
    if (wb_valid) begin
      wb_clr[wb_rd] = 1'b1;
    end else begin
      wb_clr = 32'd0;
    end
    busy_eff = busy_q & ~wb_clr;
    stall    = busy_eff[in_rs1] | busy_eff[in_rs2] | (in_we & busy_eff[in_rd]);
    in_ready = (state_q == S_IDLE) & ~stall & ~rst;
    accept   = in_valid & in_ready;
  end

  // Next-state, operand capture and scoreboard update; a set on the accept
  // edge overrides a clear of the same index, and x0 is never busy.
  always_comb begin
    state_d       = state_q;
    rf_rs1_d      = rf_rs1_q;
    rf_rs2_d      = rf_rs2_q;
    out_valid_d   = out_valid_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    out_rd_d      = out_rd_q;
    out_we_d      = out_we_q;
    out_payload_d = out_payload_q;
    acc_set       = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d       = S_READ;
          rf_rs1_d      = in_rs1;
          rf_rs2_d      = in_rs2;
          out_rd_d      = in_rd;
          out_we_d      = in_we;
          out_payload_d = in_payload;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d     = S_OUT;
        out_op1_d   = rf_rdata1;
        out_op2_d   = rf_rdata2;
        out_valid_d = 1'b1;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (accept && in_we && (in_rd != 5'd0)) begin
      acc_set[in_rd] = 1'b1;
    end else begin
      acc_set = 32'd0;
    end
    busy_d    = (busy_q & ~wb_clr) | acc_set;
    busy_d[0] = 1'b0;
  end

  // Register all state; reset abandons any in-flight instruction and its busy bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 32'd0;
      rf_rs1_q      <= 5'd0;
      rf_rs2_q      <= 5'd0;
      out_valid_q   <= 1'b0;
      out_op1_q     <= {XLEN{1'b0}};
      out_op2_q     <= {XLEN{1'b0}};
      out_rd_q      <= 5'd0;
      out_we_q      <= 1'b0;
      out_payload_q <= {PAYLOAD_W{1'b0}};
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      rf_rs1_q      <= rf_rs1_d;
      rf_rs2_q      <= rf_rs2_d;
      out_valid_q   <= out_valid_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
      out_rd_q      <= out_rd_d;
      out_we_q      <= out_we_d;
      out_payload_q <= out_payload_d;
    end
  end

  // Write port forwards writeback straight to the register file; x0 is never written.
  always_comb begin
    rf_we    = wb_valid & (wb_rd != 5'd0) & ~rst;
    rf_rd    = wb_rd;
    rf_wdata = wb_data;
  end

  assign rf_rs1      = rf_rs1_q;
  assign rf_rs2      = rf_rs2_q;
  assign out_valid   = out_valid_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_rd      = out_rd_q;
  assign out_we      = out_we_q;
  assign out_payload = out_payload_q;

endmodule
